fpu_mul_round: RTL and testbench

Post-multiply normalize/round/pack stage of the single-precision FP multiplier. It consumes the unsigned 64-bit mantissa product from the integer multiplier (two 24-bit significands, 48 significant bits), along with the sign, biased exponent sum and special-case flags from the unpack stage. It produces an IEEE-754 binary32 result with round-to-nearest-even and status flags. It uses the same start/done level handshake as the multiplier.

---
 rtl/fpu_mul_round.sv | 163 ++++++++++++++++
 tb/tb_fpu_mul_round.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fpu_mul_round.sv
// Normalize, round-to-nearest-even and pack stage of the binary32 multiplier.
// Takes the raw 48-bit significand product and returns a packed result with status flags.
module fpu_mul_round (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] prod,
   input  logic [9:0]  exp_sum,
   input  logic        sign_in,
   input  logic        nan_in,
   input  logic        inf_in,
   input  logic        zero_in,
   output logic [31:0] result,
   output logic        overflow,
   output logic        underflow,
   output logic        inexact,
   output logic        done
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_NORM  = 3'd1,
      ST_ROUND = 3'd2,
      ST_PACK  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t             state_r, state_s;
   logic [47:0]        prod_r;
   logic [9:0]         exp_r;
   logic               sign_r, nan_r, inf_r, zero_r;
   logic [22:0]        mant_r;
   logic               g_r, s_r, low_r, inx_r;
   logic signed [10:0] e_r;
   logic signed [10:0] e_base_s;
   logic               rnd_inc_s;
   logic [23:0]        rnd_sum_s;
   logic [31:0]        pack_res_s;
   logic               pack_ov_s, pack_un_s, pack_nx_s;
   logic               unused_hi_s;

   // Upper product bits are guaranteed zero by the multiplier.
   assign unused_hi_s = |prod[63:48];
   assign e_base_s    = {exp_r[9], exp_r};
   assign rnd_inc_s   = g_r & (s_r | mant_r[0]);
   assign rnd_sum_s   = {1'b0, mant_r} + {23'd0, rnd_inc_s};

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= state_s;
   end

   // Next-state logic
   always_comb begin
      state_s = ST_IDLE;
      case (state_r)
         ST_IDLE:  if (start) state_s = ST_NORM; else state_s = ST_IDLE;
         ST_NORM:  state_s = ST_ROUND;
         ST_ROUND: state_s = ST_PACK;
         ST_PACK:  state_s = ST_DONE;
         ST_DONE:  if (start) state_s = ST_DONE; else state_s = ST_IDLE;
         default:  state_s = ST_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      done = (state_r == ST_DONE);
   end

   // Result selection by special-case priority
   always_comb begin
      pack_res_s = 32'd0;
      pack_ov_s  = 1'b0;
      pack_un_s  = 1'b0;
      pack_nx_s  = 1'b0;
      if (nan_r) begin
         pack_res_s = 32'h7FC0_0000;
      end else if (inf_r) begin
         pack_res_s = {sign_r, 8'hFF, 23'd0};
      end else if (zero_r) begin
         pack_res_s = {sign_r, 31'd0};
      end else if (low_r) begin
         pack_res_s = {sign_r, 31'd0};
         pack_un_s  = 1'b1;
      end else if (e_r >= 11'sd255) begin
         pack_res_s = {sign_r, 8'hFF, 23'd0};
         pack_ov_s  = 1'b1;
         pack_nx_s  = 1'b1;
      end else if (e_r <= 11'sd0) begin
         pack_res_s = {sign_r, 31'd0};
         pack_un_s  = 1'b1;
         pack_nx_s  = 1'b1;
      end else begin
         pack_res_s = {sign_r, e_r[7:0], mant_r};
         pack_nx_s  = inx_r;
      end
   end

   // Operand latch, normalize, round and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         prod_r    <= 48'd0;
         exp_r     <= 10'd0;
         sign_r    <= 1'b0;
         nan_r     <= 1'b0;
         inf_r     <= 1'b0;
         zero_r    <= 1'b0;
         mant_r    <= 23'd0;
         g_r       <= 1'b0;
         s_r       <= 1'b0;
         low_r     <= 1'b0;
         inx_r     <= 1'b0;
         e_r       <= 11'sd0;
         result    <= 32'd0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         inexact   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  prod_r <= prod[47:0];
                  exp_r  <= exp_sum;
                  sign_r <= sign_in;
                  nan_r  <= nan_in;
                  inf_r  <= inf_in;
                  zero_r <= zero_in;
               end
            end
            ST_NORM: begin
               // A product in [2,4) shifts one extra place and bumps the exponent.
               if (prod_r[47]) begin
                  mant_r <= prod_r[46:24];
                  g_r    <= prod_r[23];
                  s_r    <= |prod_r[22:0];
                  e_r    <= e_base_s + 11'sd1;
               end else begin
                  mant_r <= prod_r[45:23];
                  g_r    <= prod_r[22];
                  s_r    <= |prod_r[21:0];
                  e_r    <= e_base_s;
               end
               low_r <= ~(prod_r[47] | prod_r[46]);
            end
            ST_ROUND: begin
               mant_r <= rnd_sum_s[22:0];
               if (rnd_sum_s[23]) e_r <= e_r + 11'sd1;
               inx_r  <= g_r | s_r;
            end
            ST_PACK: begin
               result    <= pack_res_s;
               overflow  <= pack_ov_s;
               underflow <= pack_un_s;
               inexact   <= pack_nx_s;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_mul_round.sv
// Self-checking bench for fpu_mul_round: directed cases plus random significand
// products checked against an integer-remainder rounding model.
module tb_fpu_mul_round;

   logic        clk = 1'b0;
   logic        rst, start, sign_in, nan_in, inf_in, zero_in;
   logic [63:0] prod;
   logic [9:0]  exp_sum;
   logic [31:0] result;
   logic        overflow, underflow, inexact, done;

   int errors = 0;
   int checks = 0;

   fpu_mul_round dut (
      .clk(clk), .rst(rst), .start(start), .prod(prod), .exp_sum(exp_sum),
      .sign_in(sign_in), .nan_in(nan_in), .inf_in(inf_in), .zero_in(zero_in),
      .result(result), .overflow(overflow), .underflow(underflow),
      .inexact(inexact), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: round by comparing the discarded remainder against one half.
   function automatic void model(input logic [47:0] p, input int es, input bit sg,
                                 input bit nan, input bit inf, input bit zero,
                                 output logic [31:0] r, output bit ov, output bit un,
                                 output bit nx);
      longint unsigned pp, q, rem, half;
      int sh, e;
      ov = 1'b0; un = 1'b0; nx = 1'b0;
      pp = 64'(p);
      if (nan) r = 32'h7FC0_0000;
      else if (inf) r = {sg, 8'hFF, 23'd0};
      else if (zero) r = {sg, 31'd0};
      else if (pp < 64'h0000_4000_0000_0000) begin
         r = {sg, 31'd0};
         un = 1'b1;
      end else begin
         sh = (pp >= 64'h0000_8000_0000_0000) ? 24 : 23;
         e = es + ((sh == 24) ? 1 : 0);
         q = pp >> sh;
         rem = pp - (q << sh);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && q[0])) q = q + 64'd1;
         if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
         end
         nx = (rem != 64'd0);
         if (e >= 255) begin
            r = {sg, 8'hFF, 23'd0}; ov = 1'b1; nx = 1'b1;
         end else if (e <= 0) begin
            r = {sg, 31'd0}; un = 1'b1; nx = 1'b1;
         end else begin
            r = {sg, e[7:0], q[22:0]};
         end
      end
   endfunction

   task automatic run_op(input string tag, input logic [47:0] p, input int es, input bit sg,
                         input bit nan, input bit inf, input bit zero);
      logic [31:0] er;
      bit eo, eu, ex;
      model(p, es, sg, nan, inf, zero, er, eo, eu, ex);
      prod = {16'd0, p}; exp_sum = es[9:0]; sign_in = sg;
      nan_in = nan; inf_in = inf; zero_in = zero; start = 1'b1;
      tick();
      // inputs change mid-operation must not be picked up
      prod = {16'd0, 2'b01, 46'($urandom)}; exp_sum = 10'($urandom); sign_in = ~sg;
      nan_in = 1'b0; inf_in = 1'b0; zero_in = 1'b0;
      tick();
      tick();
      chk({tag, " done_early"}, 32'(done), 32'd0);
      tick();
      chk({tag, " done"}, 32'(done), 32'd1);
      chk({tag, " result"}, result, er);
      chk({tag, " flags"}, {29'd0, overflow, underflow, inexact}, {29'd0, eo, eu, ex});
      start = 1'b0;
      tick();
      chk({tag, " done_drop"}, 32'(done), 32'd0);
   endtask

   initial begin
      logic [23:0] a, b;
      int es;
      rst = 1'b1; start = 1'b0; prod = 64'd0; exp_sum = 10'd0; sign_in = 1'b0;
      nan_in = 1'b0; inf_in = 1'b0; zero_in = 1'b0;
      tick(); tick();
      chk("reset result", result, 32'd0);
      chk("reset flags", {28'd0, overflow, underflow, inexact, done}, 32'd0);
      rst = 1'b0;
      tick();

      run_op("one",      48'h4000_0000_0000, 127, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("one value", result, 32'h3F80_0000);
      run_op("1.5sq",    48'h9000_0000_0000, 127, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("1.5sq value", result, 32'h4010_0000);
      run_op("1.5sq_n",  48'h9000_0000_0000, 127, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("1.5sq_n value", result, 32'hC010_0000);
      run_op("tie_even", 48'h4000_0040_0000, 127, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("tie_even value", result, 32'h3F80_0000);
      run_op("tie_odd",  48'h4000_00C0_0000, 127, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("tie_odd value", result, 32'h3F80_0002);
      run_op("carry",    48'h7FFF_FFC0_0000, 127, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("carry value", result, 32'h4000_0000);
      run_op("ovf",      48'h8000_0000_0000, 254, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ovf value", {result, overflow}, {32'h7F80_0000, 1'b1});
      run_op("unf",      48'h4000_0000_0000, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("unf value", {result, underflow}, {32'h8000_0000, 1'b1});
      run_op("nan_inf",  48'h4000_0000_0000, 127, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("nan_inf value", result, 32'h7FC0_0000);
      run_op("inf",      48'h8000_0000_0000, 10, 1'b1, 1'b0, 1'b1, 1'b0);
      run_op("zero",     48'h8000_0000_0000, 300, 1'b0, 1'b0, 1'b0, 1'b1);

      // start held high keeps DONE; no re-latch, result held
      prod = {16'd0, 48'h9000_0000_0000}; exp_sum = 10'd127; sign_in = 1'b0; start = 1'b1;
      tick(); tick(); tick(); tick();
      chk("hold done0", 32'(done), 32'd1);
      prod = {16'd0, 48'h4000_0000_0000}; exp_sum = 10'd100; sign_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold done", 32'(done), 32'd1);
      end
      chk("hold result", result, 32'h4010_0000);
      start = 1'b0;
      tick();
      chk("hold drop", 32'(done), 32'd0);
      chk("hold idle result", result, 32'h4010_0000);

      // reset while in ROUND
      prod = {16'd0, 48'h4000_0000_0000}; exp_sum = 10'd127; start = 1'b1;
      tick(); tick();
      rst = 1'b1; start = 1'b0;
      tick();
      chk("midrst done", 32'(done), 32'd0);
      chk("midrst result", result, 32'd0);
      rst = 1'b0;
      tick(); tick(); tick(); tick();
      chk("midrst idle", 32'(done), 32'd0);

      // reset beats start
      rst = 1'b1; start = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0;
      tick(); tick(); tick(); tick();
      chk("rst_vs_start", 32'(done), 32'd0);

      for (int n = 0; n < 40; n++) begin
         a = {1'b1, 23'($urandom)};
         b = {1'b1, 23'($urandom)};
         if (n % 4 == 0) b = 24'h80_0000;
         es = int'($urandom_range(320, 0)) - 40;
         run_op("rand", 48'(a) * 48'(b), es, 1'($urandom),
                ($urandom_range(15, 0) == 0), ($urandom_range(15, 0) == 0),
                ($urandom_range(15, 0) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
